// File: rtl/ibuf_pkg.sv
// Shared definitions for the input-buffer read path: FSM encoding and
// default widths. REGNUM_W is also used by the read-data sync stage.
package ibuf_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int SEL_W_DEF  = 4;
  localparam int REGNUM_W   = SEL_W_DEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ibuf_raddr_gen_if.sv
// Read-address beat bus between the address generator (master) and the
// buffer read port / read-data sync stage (slave).
interface ibuf_raddr_gen_if
  import ibuf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
);

  logic [ADDR_W-1:0] raddr_o;
  logic              raddr_vld_o;
  logic              raddr_rst_o;
  logic [SEL_W-1:0]  ctrl_regnum_sel_o;
  logic              ready_i;

  modport master (
    output raddr_o,
    output raddr_vld_o,
    output raddr_rst_o,
    output ctrl_regnum_sel_o,
    input  ready_i
  );

  modport slave (
    input  raddr_o,
    input  raddr_vld_o,
    input  raddr_rst_o,
    input  ctrl_regnum_sel_o,
    output ready_i
  );

endinterface

// File: rtl/ibuf_wrap_cnt.sv
// Loadable up-counter that wraps to zero after reaching 'last'.
// 'wrap' flags that the current value equals the limit, so the caller can
// decide on the same edge whether the increment is a wrap.
module ibuf_wrap_cnt
  import ibuf_pkg::*;
#(
  parameter int W = ADDR_W_DEF
) (
  input  logic         SYS_CLK,
  input  logic         SYS_NRST,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = (cnt == last);

  // Count on enable; compare happens before increment so it never overflows.
  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ibuf_raddr_gen.sv
// Input-buffer read-address generator. A start sweeps addresses
// 0..last_addr once per register number 0..last_sel, one beat per
// accepted valid/ready handshake.
// Optional build macro IBUF_RADDR_GEN_LOOP_EN adds loop_i, which restarts
// the sweep after the final beat instead of returning to IDLE.
module ibuf_raddr_gen
  import ibuf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              SYS_CLK,
  input  logic              SYS_NRST,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] cfg_last_addr_i,
  input  logic [SEL_W-1:0]  cfg_last_sel_i,
`ifdef IBUF_RADDR_GEN_LOOP_EN
  input  logic              loop_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  ibuf_raddr_gen_if.master  bus
);

  state_e            state;
  logic [ADDR_W-1:0] last_addr_q;
  logic [SEL_W-1:0]  last_sel_q;
  logic [ADDR_W-1:0] addr_cnt;
  logic [SEL_W-1:0]  sel_cnt;
  logic              addr_wrap;
  logic              sel_wrap;
  logic              beat_acc;
  logic              final_beat;
  logic              loop_on;
  logic              cnt_clr;
  logic              addr_en;
  logic              sel_en;

`ifdef IBUF_RADDR_GEN_LOOP_EN
  assign loop_on = loop_i;
`else
  assign loop_on = 1'b0;
`endif

  // Abort outranks acceptance: an aborted beat is never counted.
  assign beat_acc   = (state == ST_RUN) && bus.raddr_vld_o && bus.ready_i && !abort_i;
  assign final_beat = addr_wrap && sel_wrap;
  assign cnt_clr    = (state == ST_IDLE) && start_i;
  // On a non-looping final beat the counters hold their last values.
  assign addr_en    = beat_acc && (!final_beat || loop_on);
  assign sel_en     = addr_en && addr_wrap;

  ibuf_wrap_cnt #(.W(ADDR_W)) u_addr_cnt (
    .SYS_CLK  (SYS_CLK),
    .SYS_NRST (SYS_NRST),
    .clr      (cnt_clr),
    .en       (addr_en),
    .last     (last_addr_q),
    .cnt      (addr_cnt),
    .wrap     (addr_wrap)
  );

  ibuf_wrap_cnt #(.W(SEL_W)) u_sel_cnt (
    .SYS_CLK  (SYS_CLK),
    .SYS_NRST (SYS_NRST),
    .clr      (cnt_clr),
    .en       (sel_en),
    .last     (last_sel_q),
    .cnt      (sel_cnt),
    .wrap     (sel_wrap)
  );

  assign bus.raddr_o           = addr_cnt;
  assign bus.ctrl_regnum_sel_o = sel_cnt;

  // Sequencing FSM with registered valid/rst-marker/busy/done outputs.
  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state           <= ST_IDLE;
      last_addr_q     <= '0;
      last_sel_q      <= '0;
      bus.raddr_vld_o <= 1'b0;
      bus.raddr_rst_o <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state           <= ST_RUN;
            last_addr_q     <= cfg_last_addr_i;
            last_sel_q      <= cfg_last_sel_i;
            bus.raddr_vld_o <= 1'b1;
            bus.raddr_rst_o <= 1'b1;
            busy_o          <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            state           <= ST_IDLE;
            bus.raddr_vld_o <= 1'b0;
            bus.raddr_rst_o <= 1'b0;
            busy_o          <= 1'b0;
          end else if (beat_acc) begin
            if (final_beat) begin
              done_o <= 1'b1;
              if (loop_on) begin
                bus.raddr_rst_o <= 1'b1;
              end else begin
                state           <= ST_IDLE;
                bus.raddr_vld_o <= 1'b0;
                bus.raddr_rst_o <= 1'b0;
                busy_o          <= 1'b0;
              end
            end else begin
              // Next address is 0 exactly when the current one is the last.
              bus.raddr_rst_o <= addr_wrap;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibuf_raddr_gen.sv
// Scoreboard bench for ibuf_raddr_gen: expected beats are queued when a
// sweep is started and checked as the DUT hands them over.
module tb_ibuf_raddr_gen;
  import ibuf_pkg::*;

  localparam int ADDR_W = 8;
  localparam int SEL_W  = 4;

  logic              SYS_CLK;
  logic              SYS_NRST;
  logic              start_i;
  logic              abort_i;
  logic [ADDR_W-1:0] cfg_last_addr_i;
  logic [SEL_W-1:0]  cfg_last_sel_i;
`ifdef IBUF_RADDR_GEN_LOOP_EN
  logic              loop_i;
`endif
  logic              busy_o;
  logic              done_o;

  ibuf_raddr_gen_if #(.ADDR_W(ADDR_W), .SEL_W(SEL_W)) bus ();

  ibuf_raddr_gen #(.ADDR_W(ADDR_W), .SEL_W(SEL_W)) dut (
    .SYS_CLK         (SYS_CLK),
    .SYS_NRST        (SYS_NRST),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .cfg_last_addr_i (cfg_last_addr_i),
    .cfg_last_sel_i  (cfg_last_sel_i),
`ifdef IBUF_RADDR_GEN_LOOP_EN
    .loop_i          (loop_i),
`endif
    .busy_o          (busy_o),
    .done_o          (done_o),
    .bus             (bus)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beat: {rst_marker, sel, addr}
  typedef logic [ADDR_W+SEL_W:0] beat_t;
  beat_t sb[$];

  int done_cnt = 0;
  int busy_cyc = 0;
  int acc_cnt  = 0;

  logic              hold_pend = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [SEL_W-1:0]  prev_sel;
  logic              prev_rst;

  // Monitor mid-cycle: whatever is valid&ready now is taken at the next edge.
  always @(negedge SYS_CLK) begin
    if (SYS_NRST) begin
      beat_t e;
      if (done_o) done_cnt++;
      if (busy_o) busy_cyc++;
      chk("vld_eq_busy", {31'd0, bus.raddr_vld_o}, {31'd0, busy_o});
      if (hold_pend) begin
        chk("hold_addr", {24'd0, bus.raddr_o}, {24'd0, prev_addr});
        chk("hold_sel", {28'd0, bus.ctrl_regnum_sel_o}, {28'd0, prev_sel});
        chk("hold_rst", {31'd0, bus.raddr_rst_o}, {31'd0, prev_rst});
      end
      hold_pend = 1'b0;
      if (bus.raddr_vld_o && !abort_i) begin
        if (bus.ready_i) begin
          acc_cnt++;
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("beat_addr", {24'd0, bus.raddr_o}, {24'd0, e[ADDR_W-1:0]});
            chk("beat_sel", {28'd0, bus.ctrl_regnum_sel_o}, {28'd0, e[ADDR_W+SEL_W-1:ADDR_W]});
            chk("beat_rst", {31'd0, bus.raddr_rst_o}, {31'd0, e[ADDR_W+SEL_W]});
          end
        end else begin
          hold_pend = 1'b1;
          prev_addr = bus.raddr_o;
          prev_sel  = bus.ctrl_regnum_sel_o;
          prev_rst  = bus.raddr_rst_o;
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic step();
    @(posedge SYS_CLK);
    #2;
  endtask

  task automatic push_sweep(input int la, input int ls, input int maxn);
    int n = 0;
    for (int s = 0; s <= ls; s++) begin
      for (int a = 0; a <= la; a++) begin
        if (n < maxn) begin
          beat_t e;
          e = '0;
          e[ADDR_W-1:0]             = ADDR_W'(a);
          e[ADDR_W+SEL_W-1:ADDR_W]  = SEL_W'(s);
          e[ADDR_W+SEL_W]           = (a == 0);
          sb.push_back(e);
        end
        n++;
      end
    end
  endtask

  // Start pulse, then scramble cfg to show it is only sampled on start.
  task automatic do_start(input int la, input int ls);
    step();
    cfg_last_addr_i = ADDR_W'(la);
    cfg_last_sel_i  = SEL_W'(ls);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    cfg_last_addr_i = ADDR_W'($urandom);
    cfg_last_sel_i  = SEL_W'($urandom);
  endtask

  task automatic wait_idle(input int budget, input bit bp);
    int n = 0;
    while (busy_o && n < budget) begin
      bus.ready_i = bp ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
      step();
      n++;
    end
    if (busy_o) chk("idle_timeout", 32'd1, 32'd0);
    bus.ready_i = 1'b1;
  endtask

  int dc0, bc0, ac0;

  initial begin
    SYS_NRST = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    cfg_last_addr_i = '0;
    cfg_last_sel_i  = '0;
    bus.ready_i = 1'b1;
`ifdef IBUF_RADDR_GEN_LOOP_EN
    loop_i = 1'b0;
`endif
    #23;
    chk("rst_vld", {31'd0, bus.raddr_vld_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_addr", {24'd0, bus.raddr_o}, 32'd0);
    SYS_NRST = 1'b1;
    step();

    // Basic sweep with an ignored start in the middle.
    dc0 = done_cnt; bc0 = busy_cyc; ac0 = acc_cnt;
    push_sweep(3, 1, 1000);
    do_start(3, 1);
    chk("first_rst", {31'd0, bus.raddr_rst_o}, 32'd1);
    step(); step();
    cfg_last_addr_i = '0; cfg_last_sel_i = '0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_idle(50, 1'b0);
    step();
    chk("basic_done", done_cnt - dc0, 1);
    chk("basic_busy_cyc", busy_cyc - bc0, 8);
    chk("basic_beats", acc_cnt - ac0, 8);
    chk("basic_sb_empty", sb.size(), 0);
    chk("basic_done_low", {31'd0, done_o}, 32'd0);

    // Backpressure.
    dc0 = done_cnt; ac0 = acc_cnt;
    push_sweep(3, 1, 1000);
    bus.ready_i = 1'b1;
    do_start(3, 1);
    wait_idle(100, 1'b1);
    step();
    chk("bp_done", done_cnt - dc0, 1);
    chk("bp_beats", acc_cnt - ac0, 8);
    chk("bp_sb_empty", sb.size(), 0);

    // Degenerate single beat.
    dc0 = done_cnt; ac0 = acc_cnt;
    push_sweep(0, 0, 1000);
    do_start(0, 0);
    wait_idle(20, 1'b0);
    step();
    chk("deg_done", done_cnt - dc0, 1);
    chk("deg_beats", acc_cnt - ac0, 1);

    // Abort while beat 6 is presented.
    dc0 = done_cnt; ac0 = acc_cnt;
    push_sweep(15, 3, 5);
    do_start(15, 3);
    for (int i = 0; i < 5; i++) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_vld", {31'd0, bus.raddr_vld_o}, 32'd0);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_rst", {31'd0, bus.raddr_rst_o}, 32'd0);
    step();
    chk("abort_no_done", done_cnt - dc0, 0);
    chk("abort_beats", acc_cnt - ac0, 5);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_idle_nop", {31'd0, busy_o}, 32'd0);
    push_sweep(1, 0, 1000);
    do_start(1, 0);
    wait_idle(20, 1'b0);
    step();
    chk("abort_restart_sb", sb.size(), 0);

    // Reset mid-sweep.
    dc0 = done_cnt;
    push_sweep(3, 1, 1000);
    do_start(3, 1);
    step(); step(); step();
    SYS_NRST = 1'b0;
    #1;
    chk("mrst_vld", {31'd0, bus.raddr_vld_o}, 32'd0);
    chk("mrst_busy", {31'd0, busy_o}, 32'd0);
    chk("mrst_addr", {24'd0, bus.raddr_o}, 32'd0);
    chk("mrst_sel", {28'd0, bus.ctrl_regnum_sel_o}, 32'd0);
    chk("mrst_rst", {31'd0, bus.raddr_rst_o}, 32'd0);
    chk("mrst_done", {31'd0, done_o}, 32'd0);
    sb.delete();
    step();
    SYS_NRST = 1'b1;
    step(); step();
    chk("mrst_no_done", done_cnt - dc0, 0);
    chk("mrst_idle", {31'd0, busy_o}, 32'd0);
    push_sweep(2, 0, 1000);
    do_start(2, 0);
    wait_idle(20, 1'b0);
    step();
    chk("mrst_recover_sb", sb.size(), 0);

`ifdef IBUF_RADDR_GEN_LOOP_EN
    // Looping: three passes, then abort on the fourth pass's first beat.
    dc0 = done_cnt; ac0 = acc_cnt;
    loop_i = 1'b1;
    push_sweep(1, 0, 1000);
    push_sweep(1, 0, 1000);
    push_sweep(1, 0, 1000);
    do_start(1, 0);
    for (int i = 0; i < 6; i++) step();
    chk("loop_busy", {31'd0, busy_o}, 32'd1);
    chk("loop_restart_rst", {31'd0, bus.raddr_rst_o}, 32'd1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    loop_i = 1'b0;
    chk("loop_abort_vld", {31'd0, bus.raddr_vld_o}, 32'd0);
    step();
    chk("loop_done_cnt", done_cnt - dc0, 3);
    chk("loop_beats", acc_cnt - ac0, 6);
`endif

    chk("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ibuf_raddr_gen.md
Name: ibuf_raddr_gen

Overview:
Read-address generator for the input buffer. On a start command it sweeps the buffer memory address range once per selected register number. It produces raddr_o, raddr_vld_o, raddr_rst_o and ctrl_regnum_sel_o. These feed the read-data sync stage and the buffer memory read port directly downstream. Flow control uses a valid/ready handshake with the consumer.

Parameters:
ADDR_W, 8, width of buffer read address and length config
SEL_W, 4, width of register-number select (up to 16 registers)

Ports:
SYS_CLK  input  1  system clock, rising edge
SYS_NRST  input  1  asynchronous active-low reset
start_i  input  1  one-cycle start request; honoured only in IDLE
abort_i  input  1  terminate the current sweep
cfg_last_addr_i  input  ADDR_W  last address index per register (length-1); sampled on accepted start
cfg_last_sel_i  input  SEL_W  last register index; sampled on accepted start
ready_i  input  1  downstream accepts the current beat
raddr_o  output  ADDR_W  buffer read address
raddr_vld_o  output  1  raddr_o / ctrl_regnum_sel_o valid
raddr_rst_o  output  1  marks address 0 of each register pass
ctrl_regnum_sel_o  output  SEL_W  current register number
busy_o  output  1  sweep in progress
done_o  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Clocking and reset: single clock SYS_CLK. SYS_NRST is asynchronous, active-low. All outputs are registered and reset to 0. The FSM resets to IDLE.
- FSM states: IDLE, RUN.
- IDLE -> RUN: start_i=1 at an edge in IDLE.
  - Latch cfg_last_addr_i and cfg_last_sel_i.
  - Next cycle: raddr_vld_o=1, raddr_o=0, ctrl_regnum_sel_o=0, raddr_rst_o=1, busy_o=1.
  - Latency: 1 cycle from start to first valid beat.
- Beat accepted: raddr_vld_o & ready_i at a rising edge.
- While ready_i=0: all outputs hold their values, including raddr_rst_o.
- On an accepted beat in RUN:
  - addr < last_addr: addr+1, sel unchanged, raddr_rst_o=0.
  - addr == last_addr and sel < last_sel: addr=0, sel+1, raddr_rst_o=1.
  - addr == last_addr and sel == last_sel (final beat):
    - next cycle: raddr_vld_o=0, busy_o=0, done_o=1, raddr_rst_o=0, state IDLE;
    - raddr_o and ctrl_regnum_sel_o hold their last values;
    - done_o returns to 0 the following cycle.
- Total accepted beats per sweep: (last_addr+1)*(last_sel+1).
- Degenerate config: last_addr=0 and last_sel=0 gives exactly one beat, with raddr_rst_o=1 on that beat.
- Counters never wrap past the latched limits. No arithmetic overflow is possible because the compare happens before the increment.
- start_i while in RUN is ignored. cfg inputs may change freely during RUN with no effect.
- abort_i in RUN, which has priority over beat acceptance:
  - next cycle: raddr_vld_o=0, busy_o=0, raddr_rst_o=0, state IDLE;
  - done_o is NOT pulsed.
- abort_i in IDLE: no effect.
- start_i and abort_i together in IDLE: start wins.
- Reset asserted mid-sweep: immediate return to reset values. No done pulse.

Optional Feature:
Macro: IBUF_RADDR_GEN_LOOP_EN
- Defined: adds input loop_i.
  - If loop_i=1 when the final beat is accepted, the next cycle restarts at addr=0, sel=0, raddr_rst_o=1, raddr_vld_o=1.
  - done_o still pulses for 1 cycle, concurrent with the restart beat.
  - State stays RUN, busy_o stays 1, and the latched config is reused.
  - abort_i ends the loop.
- Undefined: no loop_i port; behaviour exactly as above.

Decomposition:
- Shared package ibuf_pkg holds:
  - FSM state encoding (IDLE=1'b0, RUN=1'b1);
  - default ADDR_W and SEL_W constants;
  - register-number width shared with the sync stage.
- One natural sub-module, ibuf_wrap_cnt: a loadable counter with last-value compare, enable and wrap-flag output. It is instantiated twice, for address and for select; the select counter is enabled by the address wrap.

Test Plan:
- Basic sweep: last_addr=3, last_sel=1, ready_i=1 -> 8 beats (0,0)(1,0)(2,0)(3,0)(0,1)(1,1)(2,1)(3,1). raddr_rst_o=1 on beats 1 and 5. done_o pulses 1 cycle after beat 8. busy_o high for 8 cycles.
- Backpressure: same config, ready_i toggled 1,0,0,1,... -> outputs frozen during ready_i=0, including raddr_rst_o. Still exactly 8 accepted beats in order. No beat is duplicated or skipped.
- Degenerate: last_addr=0, last_sel=0 -> single beat (0,0) with raddr_rst_o=1, then done_o pulse.
- Abort: last_addr=15, last_sel=3, abort_i on beat 6 -> raddr_vld_o=0 and busy_o=0 next cycle, no done_o. A new start then sweeps from (0,0).
- Ignored start and mid-sweep reset: start_i pulsed in RUN -> no effect. SYS_NRST asserted mid-sweep -> all outputs 0 asynchronously, FSM returns to IDLE.
- LOOP_EN build: loop_i=1, last_addr=1, last_sel=0 -> beats (0,0)(1,0)(0,0)(1,0)... with done_o on each restart beat. abort_i stops the sequence next cycle.
